// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory, redirect, decode and fault signals.
// master = fetch unit side, slave = memory/decode/branch side.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault, fault_pc,
    input  imem_rd, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault, fault_pc,
    output imem_rd, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, 2-entry instruction buffer, redirect flush.
// Optional misaligned-redirect trap enabled by macro FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
`else
  typedef enum logic {RUN = 1'b0} state_t;
`endif

  localparam logic [1:0] CNT_FULL = 2'(BUF_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_pc_d    [2];
  logic        pop;
  logic        fetch_en;
  logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        misaligned;

  assign target     = bus.redirect_pc;
  assign misaligned = |bus.redirect_pc[1:0];
`else
  logic unused_redirect_lsb;

  assign target              = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
`endif

  assign bus.if_valid = (state_q == RUN) && (count_q != 2'd0);
  assign pop          = bus.if_valid && bus.if_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    fetch_en    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_pc_d  = fault_pc_q;
`endif
    // A redirect wins over pop and fetch; a coincident pop is still consumed by decode.
    if (bus.redirect_valid) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned) begin
        state_d    = TRAP;
        fault_pc_d = bus.redirect_pc;
      end else begin
        state_d = RUN;
        pc_d    = target;
      end
`else
      pc_d = target;
`endif
    end else begin
      fetch_en = (state_q == RUN) && ((count_q < CNT_FULL) || pop);
      if (fetch_en) begin
        buf_instr_d[wr_ptr_q] = bus.imem_rd;
        buf_pc_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = ~wr_ptr_q;
        pc_d                  = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({fetch_en, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_pc_q <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_pc_q <= fault_pc_d;
`endif
    end
  end

  // Buffer payload needs no reset: it is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_instr    = buf_instr_q[rd_ptr_q];
  assign bus.if_pc       = buf_pc_q[rd_ptr_q];
  assign bus.if_pc_plus4 = buf_pc_q[rd_ptr_q] + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_fault = (state_q == TRAP);
  assign bus.fault_pc    = fault_pc_q;
`else
  assign bus.fetch_fault = 1'b0;
  assign bus.fault_pc    = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences, then random traffic
// compared against a queue-based reference model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign bus.imem_rd = mem_f(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          r;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          chk;
    bit          e_vld;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
  } vec_t;

  ent_t        q[$];
  logic [31:0] pc_m;
  logic [31:0] fault_pc_m;
  bit          trap_m;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_check();
    bit v;
    v = !trap_m && (q.size() != 0);
    check("if_valid", 32'(bus.if_valid), 32'(v));
    check("imem_addr", bus.imem_addr, pc_m);
    check("fetch_fault", 32'(bus.fetch_fault), 32'(trap_m));
    check("fault_pc", bus.fault_pc, fault_pc_m);
    if (v) begin
      check("if_instr", bus.if_instr, q[0].instr);
      check("if_pc", bus.if_pc, q[0].pc);
      check("if_pc_plus4", bus.if_pc_plus4, q[0].pc + 32'd4);
    end
  endtask

  task automatic model_step();
    bit pop;
    int n;
    ent_t e;
    pop = !trap_m && (q.size() != 0) && bus.if_ready;
    n   = q.size();
    if (rst) begin
      pc_m = RST_PC; q.delete(); trap_m = 1'b0; fault_pc_m = 32'd0;
    end else if (bus.redirect_valid) begin
      q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        trap_m = 1'b1; fault_pc_m = bus.redirect_pc;
      end else begin
        trap_m = 1'b0; pc_m = bus.redirect_pc;
      end
`else
      pc_m = bus.redirect_pc & ~32'h3;
`endif
    end else if (!trap_m) begin
      if (pop) void'(q.pop_front());
      if (n < 2 || pop) begin
        e.pc = pc_m; e.instr = mem_f(pc_m);
        q.push_back(e);
        pc_m = pc_m + 32'd4;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy, input bit do_chk);
    @(negedge clk);
    rst = r; bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.if_ready = rdy;
    #1;
    if (do_chk) model_check();
  endtask

  function automatic vec_t row(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy,
                               input bit chk, input bit e_vld, input logic [31:0] e_addr,
                               input logic [31:0] e_pc);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.chk = chk; v.e_vld = e_vld; v.e_addr = e_addr; v.e_pc = e_pc;
    return v;
  endfunction

  initial begin
    rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0; bus.if_ready = 1'b0;
    pc_m = RST_PC; trap_m = 1'b0; fault_pc_m = 32'd0;

    // rst rv rpc rdy | chk vld addr pc
    tbl[0]  = row(1, 0, 32'h0,          0, 0, 0, 32'h0,          32'h0);
    tbl[1]  = row(1, 0, 32'h0,          0, 1, 0, 32'h0,          32'h0);
    tbl[2]  = row(0, 0, 32'h0,          1, 1, 0, 32'h0,          32'h0);
    tbl[3]  = row(0, 0, 32'h0,          1, 1, 1, 32'h4,          32'h0);
    tbl[4]  = row(0, 0, 32'h0,          1, 1, 1, 32'h8,          32'h4);
    tbl[5]  = row(1, 0, 32'h0,          1, 1, 1, 32'hC,          32'h8);
    tbl[6]  = row(0, 0, 32'h0,          0, 1, 0, 32'h0,          32'h0);
    tbl[7]  = row(0, 0, 32'h0,          0, 1, 1, 32'h4,          32'h0);
    tbl[8]  = row(0, 0, 32'h0,          0, 1, 1, 32'h8,          32'h0);
    tbl[9]  = row(0, 0, 32'h0,          0, 1, 1, 32'h8,          32'h0);
    tbl[10] = row(0, 0, 32'h0,          0, 1, 1, 32'h8,          32'h0);
    tbl[11] = row(0, 0, 32'h0,          1, 1, 1, 32'h8,          32'h0);
    tbl[12] = row(0, 0, 32'h0,          1, 1, 1, 32'hC,          32'h4);
    tbl[13] = row(0, 0, 32'h0,          0, 1, 1, 32'h10,         32'h8);
    tbl[14] = row(0, 1, 32'h40,         1, 1, 1, 32'h10,         32'h8);
    tbl[15] = row(0, 0, 32'h0,          1, 1, 0, 32'h40,         32'h0);
    tbl[16] = row(0, 0, 32'h0,          1, 1, 1, 32'h44,         32'h40);
    tbl[17] = row(0, 1, 32'hFFFF_FFFC,  1, 1, 1, 32'h48,         32'h44);
    tbl[18] = row(0, 0, 32'h0,          0, 1, 0, 32'hFFFF_FFFC,  32'h0);
    tbl[19] = row(0, 0, 32'h0,          0, 1, 1, 32'h0,          32'hFFFF_FFFC);
    tbl[20] = row(0, 1, 32'h42,         1, 1, 1, 32'h4,          32'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_TRAP_EN
    tbl[21] = row(0, 0, 32'h0,          1, 1, 0, 32'h4,          32'h0);
    tbl[22] = row(0, 1, 32'h80,         1, 1, 0, 32'h4,          32'h0);
`else
    tbl[21] = row(0, 0, 32'h0,          1, 1, 0, 32'h40,         32'h0);
    tbl[22] = row(0, 1, 32'h80,         1, 1, 1, 32'h44,         32'h40);
`endif
    tbl[23] = row(0, 0, 32'h0,          1, 1, 0, 32'h80,         32'h0);
    tbl[24] = row(0, 0, 32'h0,          1, 1, 1, 32'h84,         32'h80);

    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].chk);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_vld", i), 32'(bus.if_valid), 32'(tbl[i].e_vld));
        check($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
        if (tbl[i].e_vld) check($sformatf("tbl%0d_pc", i), bus.if_pc, tbl[i].e_pc);
      end
      if (i == 19) check("wrap_pc_plus4", bus.if_pc_plus4, 32'h0);
      model_step();
    end

    // Reset in the middle of a stall with a full buffer.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 32'h0, 0, 1); model_step();
    end
    cycle(1, 0, 32'h0, 0, 1); model_step();
    cycle(0, 0, 32'h0, 1, 1);
    check("rst_stall_vld", 32'(bus.if_valid), 32'd0);
    check("rst_stall_addr", bus.imem_addr, RST_PC);
    model_step();

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect while trapped updates fault_pc; reset clears the trap.
    cycle(0, 1, 32'h42, 1, 1); model_step();
    cycle(0, 1, 32'h91, 1, 1);
    check("trap_fault", 32'(bus.fetch_fault), 32'd1);
    check("trap_fault_pc", bus.fault_pc, 32'h42);
    model_step();
    cycle(0, 0, 32'h0, 1, 1);
    check("trap_fault_pc2", bus.fault_pc, 32'h91);
    check("trap_vld", 32'(bus.if_valid), 32'd0);
    model_step();
    cycle(1, 0, 32'h0, 1, 1); model_step();
    cycle(0, 0, 32'h0, 1, 1);
    check("trap_rst_fault", 32'(bus.fetch_fault), 32'd0);
    check("trap_rst_fault_pc", bus.fault_pc, 32'd0);
    model_step();
`endif

    for (int i = 0; i < 3000; i++) begin
      bit          r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 1) == 1) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(0, 2) != 0);
      cycle(r, rv, rpc, rdy, 1);
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] shall be 0.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; only the value 2 is supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: imem_addr  output  32  byte address to instruction memory; equals the PC register.
REQ-006 Port: imem_rd  input  32  instruction word; combinational (same-cycle) read of imem_addr.
REQ-007 Port: redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-008 Port: redirect_pc  input  32  redirect target address.
REQ-009 Port: if_valid  output  1  buffer head holds a valid instruction.
REQ-010 Port: if_ready  input  1  decode accepts the head this cycle.
REQ-011 Port: if_instr  output  32  head instruction word.
REQ-012 Port: if_pc  output  32  address of if_instr.
REQ-013 Port: if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-014 Port: fetch_fault  output  1  misaligned redirect trap active.
REQ-015 Port: fault_pc  output  32  offending redirect target.

Function
REQ-016 A pop shall occur in a cycle when if_valid and if_ready are both 1; if_instr, if_pc and if_pc_plus4 shall hold stable while if_valid=1 and if_ready=0.
REQ-017 A fetch shall occur when the state is RUN, redirect_valid=0, and (count<2 or a pop occurs); it writes {PC, imem_rd} at the tail and sets PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0).
REQ-018 If count=2 and no pop occurs, no fetch shall occur and the PC shall hold.
REQ-019 count shall update by +1 on fetch only, -1 on pop only, and stay unchanged on fetch with pop; read and write pointers are 1-bit and wrap.
REQ-020 if_valid shall equal (count!=0) in RUN and shall be 0 in every other state.
REQ-021 Latency: an instruction fetched in cycle N shall appear at the buffer head no earlier than cycle N+1, so from RUN with an empty buffer the first if_valid=1 is one cycle after the fetch.
REQ-022 States: RUN (normal fetch) and TRAP (present only with the macro); reset enters RUN.
REQ-023 redirect_valid=1 shall take priority over pop and fetch in the same cycle: the buffer is flushed (count=0, pointers=0), PC <= target, no fetch occurs, and if_valid=0 in the next cycle.
REQ-024 The first redirected instruction shall present if_valid=1 two cycles after the redirect cycle.
REQ-025 A pop coinciding with a redirect shall still count as accepted by decode; the flush discards only the remaining entries.
REQ-026 The PC shall never change except by fetch, redirect or reset.

Reset
REQ-027 With rst=1 at a clock edge: PC=RESET_PC, count=0, pointers=0, state=RUN, fetch_fault=0, fault_pc=0.
REQ-028 Outputs in the cycle after reset: if_valid=0 and imem_addr=RESET_PC; buffer data contents are don't-care.
REQ-029 Reset shall override redirect, pop and fetch in the same cycle, including in the middle of a stall or a trap.
REQ-030 The first fetch shall occur in the first cycle with rst=0.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 shall flush the buffer and enter TRAP.
REQ-032 In TRAP: fetch_fault=1, fault_pc=target, and no fetches occur.
REQ-033 TRAP shall be left only by an aligned redirect (return to RUN, normal redirect timing) or by reset.
REQ-034 A misaligned redirect received while in TRAP shall update fault_pc.
REQ-035 Macro FETCH_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] shall be forced to 0, the TRAP state shall not exist, and fetch_fault and fault_pc shall be tied to 0.

Verification
REQ-036 Reset release with RESET_PC=0 and if_ready=1 -> imem_addr sequence 0,4,8,...; if_valid=1 from the second cycle; if_pc tracks the addresses with a one-cycle lag.
REQ-037 if_ready=0 for 5 cycles -> count saturates at 2, imem_addr freezes at 8, if_instr/if_pc hold at 0; on if_ready=1, instructions at 0,4,8 appear in order with none lost or duplicated.
REQ-038 Redirect to 0x40 with count=2 and a simultaneous pop -> if_valid=0 next cycle, imem_addr=0x40, if_pc=0x40 two cycles after the redirect.
REQ-039 Redirect to 0xFFFF_FFFC -> if_pc_plus4=0 and the next imem_addr=0.
REQ-040 With the macro: redirect to 0x42 -> fetch_fault=1, fault_pc=0x42, if_valid=0; redirect to 0x80 -> fetch_fault=0 and fetching resumes at 0x80. Without the macro: redirect to 0x42 -> fetch from 0x40, fetch_fault=0.
